// File: rtl/uart_tx_sequencer.sv
// UART mailbox sequencer: reads a length and packed payload, serialises bytes on o_tx.
// Optional UART_SEQ_PARITY_EN adds an even parity bit (8E1 instead of 8N1).
module uart_tx_sequencer #(
  parameter int          CLKS_PER_BIT   = 434,
  parameter int          LEN_IDX        = 254,
  parameter int          FLAG_IDX       = 255,
  parameter int          WR_ADDR_OFFSET = 32,
  parameter logic [31:0] DONE_VALUE     = 32'h1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_rd_data,
  output logic [31:0] o_rd_addr,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_wr_en,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [9:0] MAX_LEN = 10'(4 * LEN_IDX);

`ifdef UART_SEQ_PARITY_EN
  localparam int SW = 10;
  localparam logic [3:0] BIT_LAST = 4'd10;
`else
  localparam int SW = 9;
  localparam logic [3:0] BIT_LAST = 4'd9;
`endif

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LEN      = 3'd1;
  localparam logic [2:0] FETCH    = 3'd2;
  localparam logic [2:0] SHIFT    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;
  localparam logic [2:0] WAIT_CLR = 3'd5;

  logic [2:0]    state;
  logic [9:0]    len;
  logic [9:0]    byte_idx;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] baud;
  logic [SW-1:0] shreg;
  logic          tx;

  logic [7:0]    fetch_byte;
  logic [9:0]    len_raw;
  logic [9:0]    len_clamp;
  logic [9:0]    next_idx;
  logic [SW-1:0] load;

  // Little-endian byte select and length clamp from the combinational read port
  always_comb begin
    fetch_byte = i_rd_data[7:0];
    unique case (1'b1)
      byte_idx[1:0] == 2'd1: fetch_byte = i_rd_data[15:8];
      byte_idx[1:0] == 2'd2: fetch_byte = i_rd_data[23:16];
      byte_idx[1:0] == 2'd3: fetch_byte = i_rd_data[31:24];
      default:               fetch_byte = i_rd_data[7:0];
    endcase
    len_raw   = i_rd_data[9:0];
    len_clamp = (len_raw > MAX_LEN) ? MAX_LEN : len_raw;
    next_idx  = byte_idx + 10'd1;
`ifdef UART_SEQ_PARITY_EN
    load      = {1'b1, ^fetch_byte, fetch_byte};
`else
    load      = {1'b1, fetch_byte};
`endif
  end

  // Read index follows the state so data is valid in the same cycle
  always_comb begin
    o_rd_addr = 32'd0;
    unique case (1'b1)
      state == LEN:   o_rd_addr = 32'(LEN_IDX);
      state == FETCH: o_rd_addr = {24'd0, byte_idx[9:2]};
      state == SHIFT: o_rd_addr = {24'd0, byte_idx[9:2]};
      default:        o_rd_addr = 32'd0;
    endcase
  end

  // Flag write and status decoded from state
  always_comb begin
    o_busy    = (state != IDLE);
    o_done    = (state == DONE);
    o_wr_en   = (state == DONE);
    o_wr_addr = 32'd0;
    o_wr_data = 32'd0;
    if (state == DONE) begin
      o_wr_addr = 32'(FLAG_IDX + WR_ADDR_OFFSET);
      o_wr_data = DONE_VALUE;
    end
  end

  assign o_tx = tx;

  // Sequencer FSM, baud timing and serial shifter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      len      <= '0;
      byte_idx <= '0;
      bit_cnt  <= '0;
      baud     <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) state <= LEN;
        end
        LEN: begin
          len      <= len_clamp;
          byte_idx <= '0;
          state    <= (len_clamp == 10'd0) ? DONE : FETCH;
        end
        FETCH: begin
          shreg   <= load;
          tx      <= 1'b0;
          bit_cnt <= '0;
          baud    <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_cnt == BIT_LAST) begin
              byte_idx <= next_idx;
              state    <= (next_idx == len) ? DONE : FETCH;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              tx      <= shreg[0];
              shreg   <= {1'b1, shreg[SW-1:1]};
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DONE: begin
          state <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (!i_start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with CLKS_PER_BIT=4.
// Covers 8N1 frames, or 8E1 when UART_SEQ_PARITY_EN is defined.
module tb_uart_tx_sequencer;

  localparam int CPB = 4;
`ifdef UART_SEQ_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] rd_data;
  logic [31:0] rd_addr;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:255];
  int          cyc;
  int          errors;
  int          checks;

  uart_tx_sequencer #(
    .CLKS_PER_BIT   (CPB),
    .LEN_IDX        (254),
    .FLAG_IDX       (255),
    .WR_ADDR_OFFSET (32),
    .DONE_VALUE     (32'h1)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_rd_data (rd_data),
    .o_rd_addr (rd_addr),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data),
    .o_wr_en   (wr_en),
    .o_tx      (tx),
    .o_busy    (busy),
    .o_done    (done)
  );

  assign rd_data = (rd_addr < 32'd256) ? mem[rd_addr[7:0]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic capture(output logic [10:0] bits, output bit stable,
                         output bit found, output int t0);
    logic cur;
    found  = 1'b0;
    stable = 1'b1;
    bits   = '1;
    t0     = 0;
    cur    = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) return;
    t0 = cyc;
    for (int c = 0; c < CPB * NB; c++) begin
      if (c > 0) @(negedge clk);
      if (c % CPB == 1) bits[c / CPB] = tx;
      if (c % CPB == 0) cur = tx;
      else if (tx !== cur) stable = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL reset_tx got=%b exp=1", tx);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got busy=%b done=%b wr_en=%b exp=0", busy, done, wr_en);
    end
    checks++;
    if (rd_addr !== 32'd0 || wr_addr !== 32'd0 || wr_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_addr got rd=%0d wa=%0d wd=%0d exp=0", rd_addr, wr_addr, wr_data);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got tx=%b busy=%b exp tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_three_bytes;
    logic [7:0]  exp [3];
    logic [10:0] bits;
    bit          stable, found, got;
    int          t0, prev;
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    mem[254] = 32'd3;
    mem[0]   = 32'h0043_4241;
    prev = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      capture(bits, stable, found, t0);
      checks++;
      if (!found) begin
        errors++; $display("FAIL three_start%0d got=no start bit exp=start bit", k);
      end
      checks++;
      if (bits[8:1] !== exp[k] || bits[NB-1] !== 1'b1) begin
        errors++;
        $display("FAIL three_byte%0d got=%h stop=%b exp=%h stop=1", k, bits[8:1], bits[NB-1], exp[k]);
      end
      checks++;
      if (!stable) begin
        errors++; $display("FAIL three_timing%0d got=unstable bit exp=%0d cycles per bit", k, CPB);
      end
      if (k > 0) begin
        checks++;
        if (t0 - prev !== CPB * NB + 1) begin
          errors++; $display("FAIL three_gap%0d got=%0d exp=%0d", k, t0 - prev, CPB * NB + 1);
        end
      end
      prev = t0;
    end
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL three_wr_en got=0 exp=1");
    end
    checks++;
    if (wr_addr !== 32'd287 || wr_data !== 32'd1 || done !== 1'b1) begin
      errors++;
      $display("FAIL three_flag got addr=%0d data=%0d done=%b exp 287 1 1", wr_addr, wr_data, done);
    end
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL three_pulse got wr_en=%b done=%b exp 0 0", wr_en, done);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL three_idle got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_zero_len;
    bit got, low;
    int n;
    mem[254] = 32'd0;
    got = 1'b0;
    low = 1'b0;
    n   = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (tx !== 1'b1) low = 1'b1;
      if (wr_en === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || n > 3) begin
      errors++; $display("FAIL zero_wr_latency got=%0d found=%b exp<=3", n, got);
    end
    checks++;
    if (low) begin
      errors++; $display("FAIL zero_no_tx got=tx low exp=tx high");
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL zero_idle got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_six_bytes;
    logic [7:0]  exp [6];
    logic [10:0] bits;
    bit          stable, found, got;
    int          t0;
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    exp[3] = 8'h44; exp[4] = 8'h55; exp[5] = 8'h66;
    mem[254] = 32'd6;
    mem[0]   = 32'h4433_2211;
    mem[1]   = 32'h0000_6655;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      capture(bits, stable, found, t0);
      checks++;
      if (!found || !stable || bits[8:1] !== exp[k] || bits[NB-1] !== 1'b1) begin
        errors++;
        $display("FAIL six_byte%0d got=%h found=%b stable=%b exp=%h", k, bits[8:1], found, stable, exp[k]);
      end
    end
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL six_wr_en got=0 exp=1");
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_byte_07;
    logic [10:0] bits;
    logic [10:0] exp;
    bit          stable, found;
    int          t0;
`ifdef UART_SEQ_PARITY_EN
    exp = 11'h60E;
`else
    exp = 11'h20E;
`endif
    mem[254] = 32'd1;
    mem[0]   = 32'h0000_0007;
    @(negedge clk);
    start = 1'b1;
    capture(bits, stable, found, t0);
    checks++;
    if (!found || bits[NB-1:0] !== exp[NB-1:0]) begin
      errors++; $display("FAIL frame_07 got=%h exp=%h", bits[NB-1:0], exp[NB-1:0]);
    end
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold_start;
    logic [10:0] bits;
    bit          stable, found, got;
    int          t0, bad;
    mem[254] = 32'd1;
    mem[0]   = 32'h0000_00A5;
    @(negedge clk);
    start = 1'b1;
    capture(bits, stable, found, t0);
    checks++;
    if (!found || bits[8:1] !== 8'hA5) begin
      errors++; $display("FAIL hold_byte got=%h exp=a5", bits[8:1]);
    end
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL hold_wr_en got=0 exp=1");
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || wr_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_quiet got=%0d bad cycles exp=0", bad);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL hold_busy got=%b exp=1", busy);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL hold_release got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_reset_mid;
    bit found;
    int bad;
    mem[254] = 32'd3;
    mem[0]   = 32'h0043_4241;
    found = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    repeat (4 * CPB) @(negedge clk);
    checks++;
    if (!found || tx !== 1'b0) begin
      errors++; $display("FAIL mid_bit3 got tx=%b found=%b exp tx=0", tx, found);
    end
    #2;
    rst   = 1'b1;
    start = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset got tx=%b busy=%b exp tx=1 busy=0", tx, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mid_after got=%0d bad cycles exp=0", bad);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    rst    = 1'b1;
    start  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    test_reset();
    test_three_bytes();
    test_zero_len();
    test_six_bytes();
    test_byte_07();
    test_hold_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
